// File: rtl/vend_arb_pkg.sv
// Shared types for the two-panel vending arbiter.
// Holds the state encoding, owner codes and the registered pulse bundle.
// Imported by vend_share_arbiter; vend_timer needs none of it.
package vend_arb_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        OWNED       = 2'd1,
        WAIT_REFUND = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_A    = 2'b01;
    localparam logic [1:0] OWN_B    = 2'b10;

    // Every single-cycle output pulse, registered together.
    typedef struct packed {
        logic fsm_coin;
        logic fsm_refund_request;
        logic cola_a;
        logic cola_b;
        logic refund_a;
        logic refund_b;
        logic reject_a;
        logic reject_b;
        logic timeout_evt;
        logic err_evt;
    } pulse_t;

endpackage

// File: rtl/vend_timer.sv
// Count-up timer with synchronous clear and a terminal-count flag.
// done is combinational from the count register: high while count == TERM-1.
// No backpressure; the owner leaves the counting state before it wraps.
module vend_timer #(
    parameter int unsigned W    = 4,
    parameter int unsigned TERM = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_done
);

    logic [W-1:0] r_cnt;

    // Clear wins over enable so a fresh grant always starts from zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_done = (r_cnt == W'(TERM - 1));

endmodule

// File: rtl/vend_share_arbiter.sv
// Shares one vending FSM between panels A and B, one transaction at a time.
// Panel->FSM and FSM->panel pulses all take exactly one cycle (registered).
// No backpressure: coins that cannot be accepted are bounced via reject_x.
module vend_share_arbiter
    import vend_arb_pkg::*;
#(
    parameter int unsigned IDLE_TIMEOUT = 1000,
    parameter int unsigned RESP_TIMEOUT = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       coin_a,
    input  logic       coin_b,
    input  logic       refund_req_a,
    input  logic       refund_req_b,
    input  logic       fsm_cola,
    input  logic       fsm_refund,
    output logic       fsm_coin,
    output logic       fsm_refund_request,
    output logic       cola_a,
    output logic       cola_b,
    output logic       refund_a,
    output logic       refund_b,
    output logic       reject_a,
    output logic       reject_b,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout_evt,
    output logic       err_evt
);

    localparam int unsigned TMAX = (IDLE_TIMEOUT > RESP_TIMEOUT) ? IDLE_TIMEOUT : RESP_TIMEOUT;
    localparam int unsigned TW   = $clog2(TMAX);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_owner, w_owner_nxt;
    logic [1:0] r_rr, w_rr_nxt;
    logic [1:0] w_grant;
    pulse_t     r_pls, w_pls_nxt;

    logic w_is_a, w_own_coin, w_own_req;
    logic w_rej_own;
    logic w_idle_clr, w_idle_done, w_resp_done;

    assign w_is_a     = (r_owner == OWN_A);
    assign w_own_coin = w_is_a ? coin_a       : coin_b;
    assign w_own_req  = w_is_a ? refund_req_a : refund_req_b;

    vend_timer #(.W(TW), .TERM(IDLE_TIMEOUT)) u_idle_tmr (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_clr   (w_idle_clr),
        .i_en    (r_state == OWNED),
        .o_done  (w_idle_done)
    );

    vend_timer #(.W(TW), .TERM(RESP_TIMEOUT)) u_resp_tmr (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_clr   (r_state != WAIT_REFUND),
        .i_en    (r_state == WAIT_REFUND),
        .o_done  (w_resp_done)
    );

    // Next state, ownership and output pulses for the coming cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr;
        w_grant     = OWN_NONE;
        w_pls_nxt   = '0;
        w_rej_own   = 1'b0;
        w_idle_clr  = 1'b0;

        case (r_state)
            IDLE: begin
                w_idle_clr = 1'b1;
                if (coin_a && coin_b) begin
                    w_grant = r_rr;
                    if (r_rr == OWN_A) w_pls_nxt.reject_b = 1'b1;
                    else               w_pls_nxt.reject_a = 1'b1;
                end else if (coin_a) begin
                    w_grant = OWN_A;
                end else if (coin_b) begin
                    w_grant = OWN_B;
                end
                if (w_grant != OWN_NONE) begin
                    w_owner_nxt        = w_grant;
                    w_rr_nxt           = (w_grant == OWN_A) ? OWN_B : OWN_A;
                    w_pls_nxt.fsm_coin = 1'b1;
                    w_state_nxt        = OWNED;
                end
            end

            OWNED: begin
                // The other panel's coins always bounce while someone owns the FSM.
                if (w_is_a) w_pls_nxt.reject_b = coin_b;
                else        w_pls_nxt.reject_a = coin_a;

                if (fsm_cola) begin
                    w_pls_nxt.cola_a = w_is_a;
                    w_pls_nxt.cola_b = !w_is_a;
                    w_rej_own        = w_own_coin;
                    w_owner_nxt      = OWN_NONE;
                    w_state_nxt      = IDLE;
                end else if (fsm_refund) begin
                    w_pls_nxt.refund_a = w_is_a;
                    w_pls_nxt.refund_b = !w_is_a;
                    w_rej_own          = w_own_coin;
                    w_owner_nxt        = OWN_NONE;
                    w_state_nxt        = IDLE;
                end else if (w_own_req) begin
                    w_pls_nxt.fsm_refund_request = 1'b1;
                    w_rej_own                    = w_own_coin;
                    w_state_nxt                  = WAIT_REFUND;
                end else if (w_idle_done) begin
                    w_pls_nxt.fsm_refund_request = 1'b1;
                    w_pls_nxt.timeout_evt        = 1'b1;
                    w_rej_own                    = w_own_coin;
                    w_state_nxt                  = WAIT_REFUND;
                end else if (w_own_coin) begin
                    w_pls_nxt.fsm_coin = 1'b1;
                    w_idle_clr         = 1'b1;
                end

                if (w_rej_own) begin
                    if (w_is_a) w_pls_nxt.reject_a = 1'b1;
                    else        w_pls_nxt.reject_b = 1'b1;
                end
            end

            WAIT_REFUND: begin
                w_pls_nxt.reject_a = coin_a;
                w_pls_nxt.reject_b = coin_b;
                if (fsm_refund || fsm_cola) begin
                    w_pls_nxt.refund_a = fsm_refund && w_is_a;
                    w_pls_nxt.refund_b = fsm_refund && !w_is_a;
                    w_pls_nxt.cola_a   = fsm_cola && w_is_a;
                    w_pls_nxt.cola_b   = fsm_cola && !w_is_a;
                    w_owner_nxt        = OWN_NONE;
                    w_state_nxt        = IDLE;
                end else if (w_resp_done) begin
                    // FSM never answered: drop the credit and free the FSM.
                    w_pls_nxt.err_evt = 1'b1;
                    w_owner_nxt       = OWN_NONE;
                    w_state_nxt       = IDLE;
                end
            end

            default: begin
                w_owner_nxt = OWN_NONE;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, ownership, fairness pointer and all output pulses.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
            r_owner <= OWN_NONE;
            r_rr    <= OWN_A;
            r_pls   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_rr    <= w_rr_nxt;
            r_pls   <= w_pls_nxt;
        end
    end

    assign fsm_coin           = r_pls.fsm_coin;
    assign fsm_refund_request = r_pls.fsm_refund_request;
    assign cola_a             = r_pls.cola_a;
    assign cola_b             = r_pls.cola_b;
    assign refund_a           = r_pls.refund_a;
    assign refund_b           = r_pls.refund_b;
    assign reject_a           = r_pls.reject_a;
    assign reject_b           = r_pls.reject_b;
    assign timeout_evt        = r_pls.timeout_evt;
    assign err_evt            = r_pls.err_evt;
    assign owner              = r_owner;
    assign busy               = (r_state != IDLE);

endmodule

// File: tb/tb_vend_share_arbiter.sv
// Directed bench for vend_share_arbiter; the bench itself plays the shared FSM.
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
// All expectations are hand-derived constants.
module tb_vend_share_arbiter;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       coin_a, coin_b, refund_req_a, refund_req_b, fsm_cola, fsm_refund;
    logic       fsm_coin, fsm_refund_request, cola_a, cola_b, refund_a, refund_b;
    logic       reject_a, reject_b, busy, timeout_evt, err_evt;
    logic [1:0] owner;
    logic [12:0] w_obs;

    int n_cmp = 0;
    int n_err = 0;

    // Output pulse codes, order matches w_obs[12:3].
    localparam logic [9:0] P_NONE  = 10'h000;
    localparam logic [9:0] P_COIN  = 10'h200;
    localparam logic [9:0] P_REQ   = 10'h100;
    localparam logic [9:0] P_COLAA = 10'h080;
    localparam logic [9:0] P_COLAB = 10'h040;
    localparam logic [9:0] P_REFA  = 10'h020;
    localparam logic [9:0] P_REFB  = 10'h010;
    localparam logic [9:0] P_REJA  = 10'h008;
    localparam logic [9:0] P_REJB  = 10'h004;
    localparam logic [9:0] P_TMO   = 10'h002;
    localparam logic [9:0] P_ERR   = 10'h001;

    always #5 sys_clk = ~sys_clk;

    vend_share_arbiter #(.IDLE_TIMEOUT(8), .RESP_TIMEOUT(4)) dut (
        .sys_clk            (sys_clk),
        .sys_rst_n          (sys_rst_n),
        .coin_a             (coin_a),
        .coin_b             (coin_b),
        .refund_req_a       (refund_req_a),
        .refund_req_b       (refund_req_b),
        .fsm_cola           (fsm_cola),
        .fsm_refund         (fsm_refund),
        .fsm_coin           (fsm_coin),
        .fsm_refund_request (fsm_refund_request),
        .cola_a             (cola_a),
        .cola_b             (cola_b),
        .refund_a           (refund_a),
        .refund_b           (refund_b),
        .reject_a           (reject_a),
        .reject_b           (reject_b),
        .owner              (owner),
        .busy               (busy),
        .timeout_evt        (timeout_evt),
        .err_evt            (err_evt)
    );

    assign w_obs = {fsm_coin, fsm_refund_request, cola_a, cola_b, refund_a, refund_b,
                    reject_a, reject_b, timeout_evt, err_evt, owner, busy};

    task automatic chk(input string tag, input logic [12:0] exp);
        n_cmp++;
        assert (w_obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b required %b", tag, w_obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then land 1 ns after the sampling edge.
    task automatic cyc(input logic ca, input logic cb, input logic ra, input logic rb,
                       input logic fc, input logic fr);
        coin_a = ca; coin_b = cb; refund_req_a = ra; refund_req_b = rb;
        fsm_cola = fc; fsm_refund = fr;
        @(posedge sys_clk);
        #1;
        coin_a = 0; coin_b = 0; refund_req_a = 0; refund_req_b = 0;
        fsm_cola = 0; fsm_refund = 0;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst_n = 1'b0;
        coin_a = 0; coin_b = 0; refund_req_a = 0; refund_req_b = 0;
        fsm_cola = 0; fsm_refund = 0;
        #3;
        chk("reset_state", {P_NONE, 2'b00, 1'b0});
        do_reset();
        chk("after_release", {P_NONE, 2'b00, 1'b0});

        // Basic vend: coins at t0 and t0+5, FSM answers cola at t0+7.
        cyc(1, 0, 0, 0, 0, 0);
        chk("basic_coin1", {P_COIN, 2'b01, 1'b1});
        repeat (4) idle();
        chk("basic_quiet", {P_NONE, 2'b01, 1'b1});
        cyc(1, 0, 0, 0, 0, 0);
        chk("basic_coin2", {P_COIN, 2'b01, 1'b1});
        idle();
        chk("basic_coin2_width", {P_NONE, 2'b01, 1'b1});
        cyc(0, 0, 0, 0, 1, 0);
        chk("basic_cola_a", {P_COLAA, 2'b00, 1'b0});
        idle();
        chk("basic_cola_width", {P_NONE, 2'b00, 1'b0});

        // Contention from reset; FSM pulses and refund buttons ignored in IDLE.
        do_reset();
        cyc(0, 0, 1, 1, 1, 1);
        chk("idle_ignores", {P_NONE, 2'b00, 1'b0});
        cyc(1, 1, 0, 0, 0, 0);
        chk("contend_grant_a", {P_COIN | P_REJB, 2'b01, 1'b1});
        cyc(0, 0, 0, 0, 1, 0);
        chk("contend_cola_a", {P_COLAA, 2'b00, 1'b0});
        cyc(1, 1, 0, 0, 0, 0);
        chk("contend_grant_b", {P_COIN | P_REJA, 2'b10, 1'b1});
        cyc(0, 0, 0, 0, 1, 0);
        chk("contend_cola_b", {P_COLAB, 2'b00, 1'b0});

        // Foreign coin, foreign refund button, then owner refund.
        cyc(1, 0, 0, 0, 0, 0);
        chk("foreign_grant_a", {P_COIN, 2'b01, 1'b1});
        cyc(0, 1, 0, 0, 0, 0);
        chk("foreign_reject_b", {P_REJB, 2'b01, 1'b1});
        cyc(0, 0, 0, 1, 0, 0);
        chk("foreign_req_ignored", {P_NONE, 2'b01, 1'b1});
        cyc(0, 0, 1, 0, 0, 0);
        chk("owner_refund_req", {P_REQ, 2'b01, 1'b1});
        cyc(1, 0, 0, 0, 0, 0);
        chk("wait_rejects_coin", {P_REJA, 2'b01, 1'b1});
        cyc(0, 0, 0, 0, 0, 1);
        chk("refund_a_routed", {P_REFA, 2'b00, 1'b0});

        // Idle timeout: B coin, then silence for 8 cycles.
        cyc(0, 1, 0, 0, 0, 0);
        chk("tmo_grant_b", {P_COIN, 2'b10, 1'b1});
        for (int i = 0; i < 7; i++) begin
            idle();
            chk("tmo_not_yet", {P_NONE, 2'b10, 1'b1});
        end
        idle();
        chk("tmo_fire", {P_REQ | P_TMO, 2'b10, 1'b1});
        cyc(0, 0, 0, 0, 0, 1);
        chk("tmo_refund_b", {P_REFB, 2'b00, 1'b0});

        // Response loss: refund request with a silent FSM.
        cyc(1, 0, 0, 0, 0, 0);
        chk("loss_grant_a", {P_COIN, 2'b01, 1'b1});
        cyc(0, 0, 1, 0, 0, 0);
        chk("loss_req", {P_REQ, 2'b01, 1'b1});
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("loss_waiting", {P_NONE, 2'b01, 1'b1});
        end
        idle();
        chk("loss_err", {P_ERR, 2'b00, 1'b0});
        idle();
        chk("loss_err_width", {P_NONE, 2'b00, 1'b0});

        // Coin with refund button, then reset inside WAIT_REFUND (rr is B here).
        cyc(1, 0, 0, 0, 0, 0);
        chk("simul_grant_a", {P_COIN, 2'b01, 1'b1});
        cyc(1, 0, 1, 0, 0, 0);
        chk("simul_req_rej", {P_REQ | P_REJA, 2'b01, 1'b1});
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("async_reset_clear", {P_NONE, 2'b00, 1'b0});
        #2;
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        idle();
        chk("no_pulse_on_release", {P_NONE, 2'b00, 1'b0});
        cyc(1, 1, 0, 0, 0, 0);
        chk("rr_reset_to_a", {P_COIN | P_REJB, 2'b01, 1'b1});
        cyc(0, 0, 0, 0, 1, 0);
        chk("final_cola_a", {P_COLAA, 2'b00, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vend_share_arbiter.md
# vend_share_arbiter

Shares one `simple_fsm_refund` vending FSM between two customer panels (A and B). The arbiter grants the FSM to one panel per transaction and forwards only that panel's coin and refund pulses. It routes the FSM's cola/refund pulses back to the owning panel and rejects coins from the other panel. It also auto-refunds an abandoned transaction after an idle timeout and recovers if the FSM never answers a refund request.

## Interface
- `IDLE_TIMEOUT`, default 1000: cycles without an owner coin before the arbiter auto-refunds (≥2).
- `RESP_TIMEOUT`, default 16: cycles to wait for `fsm_refund` after a refund request before abandoning (≥2).
- `sys_clk` in 1: single clock; all logic is on the rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `coin_a`, `coin_b` in 1: coin pulses, one cycle each, synchronous to `sys_clk`.
- `refund_req_a`, `refund_req_b` in 1: refund-button pulses, one cycle each.
- `fsm_cola`, `fsm_refund` in 1: pulses from the shared FSM.
- `fsm_coin`, `fsm_refund_request` out 1: registered pulses to the shared FSM.
- `cola_a`, `cola_b`, `refund_a`, `refund_b` out 1: registered pulses routed to the owner.
- `reject_a`, `reject_b` out 1: registered pulse meaning "coin returned, not accepted".
- `owner` out 2: 2'b00 none, 2'b01 A, 2'b10 B.
- `busy` out 1: high when state ≠ IDLE.
- `timeout_evt`, `err_evt` out 1: one-cycle event pulses.

## Operation
- **States:** IDLE, OWNED, WAIT_REFUND. Reset enters IDLE. Reset values: `owner` = 0, round-robin pointer `rr` = A, timers = 0, all outputs 0.
- **IDLE**
  - One coin (A or B): grant that panel, pulse `fsm_coin`, clear the idle timer, go to OWNED.
  - Coins from both panels in the same cycle: grant the panel `rr` points to. The other panel gets `reject_x`.
  - After any grant, `rr` points to the non-granted panel.
  - `refund_req_x` is ignored (no credit held).
  - `fsm_cola`/`fsm_refund` are ignored (no owner); no output pulses.
- **OWNED**, evaluated per cycle in this priority order:
  1. `fsm_cola`: pulse `cola_owner`, go to IDLE (`owner` → 0). An owner coin in the same cycle is rejected.
  2. `fsm_refund` (unsolicited): pulse `refund_owner`, go to IDLE.
  3. Owner `refund_req`: pulse `fsm_refund_request`, go to WAIT_REFUND. An owner coin in the same cycle is rejected.
  4. Idle timer reaches `IDLE_TIMEOUT-1`: pulse `fsm_refund_request` and `timeout_evt`, go to WAIT_REFUND.
  5. Owner coin: pulse `fsm_coin`, clear the idle timer.
  - Idle timer: increments every cycle without an owner coin.
  - Non-owner coin: `reject_x` in every case.
  - Non-owner `refund_req`: ignored.
- **WAIT_REFUND**
  - All coins are rejected; all `refund_req` are ignored.
  - `fsm_refund` or `fsm_cola`: route it to the owner, go to IDLE.
  - Response timer reaches `RESP_TIMEOUT-1` with no response: pulse `err_evt`, go to IDLE with no routed pulse.
- **Timer widths:** `$clog2(max timeout)` bits. Saturation is not needed because every terminal count forces a state exit.

## Timing
- All outputs are registered.
- Latency from a panel pulse to `fsm_coin`/`fsm_refund_request`/`reject_x` is exactly 1 cycle.
- Latency from an FSM pulse to `cola_x`/`refund_x` is 1 cycle.
- Every output pulse is exactly 1 cycle wide. No output is high for 2 consecutive cycles from a single event.
- `owner` and `busy` change on the same edge as the state change:
  - 1 cycle after the granting coin.
  - Cleared on the same edge that emits the routed cola/refund pulse.
- A coin arriving in the cycle after the return to IDLE can be granted immediately, so back-to-back transactions have no dead cycle.
- Idle timeout fires exactly `IDLE_TIMEOUT` cycles after the last accepted owner coin (`fsm_refund_request` on the following edge).
- Asserting `sys_rst_n` low mid-transaction:
  - Outputs clear immediately (asynchronous).
  - Credit is lost.
  - No pulses are emitted on release.

## Structure
- Package `vend_arb_pkg`:
  - `state_t` enum (IDLE, OWNED, WAIT_REFUND).
  - `owner_t` encoding constants (`OWN_NONE`, `OWN_A`, `OWN_B`).
- Sub-module `vend_timer`:
  - Parameterised count-up timer with `clr`, `en`, and terminal-count `done` output.
  - Instantiated twice: idle timer and response timer.
- The top holds the state register, `rr` pointer, and output registers, and is sized 150–250 lines.

## Test plan
- **Basic vend:** `coin_a` at t0, `coin_a` at t0+5.
  - `fsm_coin` at t0+1 and t0+6; `owner` = 01 from t0+1.
  - Model returns `fsm_cola` at t0+7 → `cola_a` at t0+8, `owner` = 00 at t0+8.
- **Contention:** `coin_a` and `coin_b` in the same cycle from reset.
  - Response: A granted, `reject_b` = 1.
  - Repeat after the transaction completes → B granted, `reject_a` = 1.
- **Foreign coin and refund:** A owns; `coin_b` pulses → `reject_b` only, `fsm_coin` stays 0.
  - Then `refund_req_a` → `fsm_refund_request` after 1 cycle.
  - `fsm_refund` from the model → `refund_a`, return to IDLE.
- **Idle timeout:** with `IDLE_TIMEOUT`=8, one `coin_b` and no further input.
  - `timeout_evt` and `fsm_refund_request` exactly 8 cycles after `fsm_coin`.
  - Model refund → `refund_b`.
- **Response loss:** with `RESP_TIMEOUT`=4, request a refund and the model stays silent.
  - `err_evt` 4 cycles after `fsm_refund_request`; `owner` = 00, no `refund_x`.
- **Simultaneous and reset:**
  - `coin_a` in the same cycle as `refund_req_a` → refund request issued, `reject_a` = 1.
  - Reset pulse while in WAIT_REFUND → all outputs 0, state IDLE, `rr` = A.
